// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers for the pipelined radix-4 word multiplexer tree.
// Level k consumes sel bits [2k+1:2k]; an odd select width ends in a 2:1 tail.
package mux_tree_pkg;

  localparam int MAX_SELW = 6;

  function automatic int sel_width(input int num_in);
    return $clog2(num_in);
  endfunction

  function automatic int num_levels(input int num_in);
    return (sel_width(num_in) + 1) / 2;
  endfunction

  function automatic int level_sel_bits(input int num_in, input int k);
    return (sel_width(num_in) - 2 * k >= 2) ? 2 : 1;
  endfunction

  function automatic int level_fan_in(input int num_in, input int k);
    return 1 << level_sel_bits(num_in, k);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_SELW-1:0] sel_rem;
  } stage_t;

endpackage

// File: rtl/mux_level.sv
// One combinational tree level: GROUPS independent RADIX:1 word muxes sharing one select.
// Group g picks word g*RADIX + sel, so the low sel bits resolve first.
module mux_level #(
  parameter int GROUPS   = 1,
  parameter int SEL_BITS = 2,
  parameter int WIDTH    = 64,
  localparam int RADIX   = 1 << SEL_BITS
) (
  input  logic [GROUPS*RADIX*WIDTH-1:0] data,
  input  logic [SEL_BITS-1:0]           sel,
  output logic [GROUPS*WIDTH-1:0]       out_data
);

  always_comb begin
    out_data = '0;
    for (int g = 0; g < GROUPS; g++) begin
      out_data[g*WIDTH +: WIDTH] = data[(g * RADIX + int'(sel)) * WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 word multiplexer built from radix-4 levels (2:1 tail when needed).
// Unconsumed select bits travel alongside the partial word groups through each stage.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int WIDTH  = 64,
  parameter int PIPE   = 1,
  localparam int SELW  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]         in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
);

  localparam int LEVELS = num_levels(NUM_IN);

  // Handshake: a transfer happens on valid && ready at either port. The whole pipe
  // advances in lockstep whenever the output slot is empty or being drained, so
  // in_ready is that same advance condition and bubbles are never squeezed out.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NW     = NUM_IN >> (2 * k);
    localparam int SW     = SELW - 2 * k;
    localparam int RB     = level_sel_bits(NUM_IN, k);
    localparam int GROUPS = NW >> RB;
    localparam bit LAST   = (k == LEVELS - 1);
    localparam bit REG    = (PIPE != 0) || LAST;

    logic [NW*WIDTH-1:0]     d_in;
    logic [SW-1:0]           s_in;
    logic                    v_in;
    logic [GROUPS*WIDTH-1:0] d_mux;
    logic [GROUPS*WIDTH-1:0] d_out;
    logic                    v_out;

    if (k == 0) begin : g_src
      assign d_in = in_data;
      assign s_in = in_sel;
      assign v_in = in_valid;
    end else begin : g_src
      assign d_in = g_lvl[k-1].d_out;
      assign s_in = g_lvl[k-1].g_rem.s_out;
      assign v_in = g_lvl[k-1].v_out;
    end

    mux_level #(
      .GROUPS   (GROUPS),
      .SEL_BITS (RB),
      .WIDTH    (WIDTH)
    ) u_mux (
      .data     (d_in),
      .sel      (s_in[RB-1:0]),
      .out_data (d_mux)
    );

    if (REG) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_out <= 1'b0;
          d_out <= '0;
        end else if (adv) begin
          v_out <= v_in;
          d_out <= d_mux;
        end
      end
    end else begin : g_comb
      assign v_out = v_in;
      assign d_out = d_mux;
    end

    // The final level consumes the last select bits, so only inner levels forward any.
    if (!LAST) begin : g_rem
      logic [SW-RB-1:0] s_out;
      if (PIPE != 0) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            s_out <= '0;
          end else if (adv) begin
            s_out <= s_in[SW-1:RB];
          end
        end
      end else begin : g_comb
        assign s_out = s_in[SW-1:RB];
      end
    end
  end

  assign out_valid = g_lvl[LEVELS-1].v_out;
  assign out_data  = g_lvl[LEVELS-1].d_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three configurations (8x8 pipelined, 32x16 unpipelined, 2x1)
// driven one at a time against a word-table model and an expected-output queue.
module tb_mux_tree_pipe;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus, steered to one DUT at a time
  logic         in_valid;
  logic         out_ready;
  logic [5:0]   in_sel;
  int           dut_id;

  logic [63:0]  d0;
  logic [511:0] d1;
  logic [1:0]   d2;
  logic         v0, v1, v2;
  logic         r0, r1, r2;
  logic         ov0, ov1, ov2;
  logic [7:0]   od0;
  logic [15:0]  od1;
  logic [0:0]   od2;

  logic         obs_valid;
  logic         obs_in_ready;
  logic [15:0]  obs_data;

  assign v0 = in_valid && (dut_id == 0);
  assign v1 = in_valid && (dut_id == 1);
  assign v2 = in_valid && (dut_id == 2);

  mux_tree_pipe #(.NUM_IN(8), .WIDTH(8), .PIPE(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .in_sel(in_sel[2:0]), .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
  );

  mux_tree_pipe #(.NUM_IN(32), .WIDTH(16), .PIPE(0)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_sel(in_sel[4:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
  );

  mux_tree_pipe #(.NUM_IN(2), .WIDTH(1), .PIPE(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .in_sel(in_sel[0:0]), .out_valid(ov2), .out_ready(out_ready), .out_data(od2)
  );

  always_comb begin
    obs_valid    = 1'b0;
    obs_in_ready = 1'b0;
    obs_data     = '0;
    case (dut_id)
      0:       begin obs_valid = ov0; obs_in_ready = r0; obs_data = {8'h00, od0};  end
      1:       begin obs_valid = ov1; obs_in_ready = r1; obs_data = od1;           end
      default: begin obs_valid = ov2; obs_in_ready = r2; obs_data = {15'h0, od2}; end
    endcase
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int          tin_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cur_lat;
  bit          chk_lat;
  bit          head_seen;
  bit          stalled;
  logic [15:0] held_data;
  logic        last_ov;

  // Expected word straight from the data pattern loaded into each DUT.
  function automatic logic [15:0] model(input int id, input int sel);
    case (id)
      0:       return 16'(sel * 'h11);
      1:       return 16'(sel * 'h0101 + 'h1000);
      default: return 16'(sel);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one cycle, entered and left at a falling edge
  task automatic step(input logic v, input int s, input logic r);
    in_valid  = v;
    in_sel    = 6'(s);
    out_ready = r;
    #1;
    check("in_ready_rule", 32'(obs_in_ready), 32'(!obs_valid || r));
    if (stalled) begin
      check("hold_valid", 32'(obs_valid), 32'd1);
      check("hold_data", 32'(obs_data), 32'(held_data));
    end
    if (obs_valid) begin
      check("unexpected_out", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        if (chk_lat && !head_seen) check("latency", 32'(cyc - tin_q[0]), 32'(cur_lat));
        head_seen = 1'b1;
        if (r) begin
          check("out_data", 32'(obs_data), 32'(exp_q.pop_front()));
          void'(tin_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
    last_ov   = obs_valid;
    stalled   = obs_valid && !r;
    held_data = obs_data;
    if (v && obs_in_ready) begin
      exp_q.push_back(model(dut_id, s));
      tin_q.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 0, 1'b1);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    dut_id    = 0;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b1;
    cur_lat   = 2;
    chk_lat   = 1'b1;
    head_seen = 1'b0;
    stalled   = 1'b0;
    held_data = '0;
    last_ov   = 1'b0;
    for (int i = 0; i < 8; i++)  d0[i*8 +: 8]   = 8'(i * 'h11);
    for (int i = 0; i < 32; i++) d1[i*16 +: 16] = 16'(i * 'h0101 + 'h1000);
    d2 = 2'b10;

    // reset state, while reset is held and just after release
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_od0", 32'(od0), 32'd0);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_od1", 32'(od1), 32'd0);
    check("rst_ov2", 32'(ov2), 32'd0);
    check("rst_od2", 32'(od2), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready0", 32'(r0), 32'd1);
    check("rst_in_ready1", 32'(r1), 32'd1);
    check("rst_in_ready2", 32'(r2), 32'd1);
    @(negedge clk);

    // 8:1 pipelined, sel 0..7 back to back
    for (int s = 0; s < 8; s++) step(1'b1, s, 1'b1);
    drain();

    // output stall for 5 cycles after the first result
    chk_lat = 1'b0;
    step(1'b1, 0, 1'b1);
    step(1'b1, 1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 2, 1'b0);
    for (int s = 2; s < 8; s++) step(1'b1, s, 1'b1);
    drain();

    // input bubble between two requests
    chk_lat = 1'b1;
    step(1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1);
    step(1'b0, 0, 1'b1);
    check("bubble_gap", 32'(last_ov), 32'd0);
    drain();

    // reset with two requests in flight
    step(1'b1, 1, 1'b1);
    step(1'b1, 2, 1'b1);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midrst_ov", 32'(ov0), 32'd0);
    check("midrst_od", 32'(od0), 32'd0);
    check("midrst_in_ready", 32'(r0), 32'd1);
    exp_q.delete();
    tin_q.delete();
    head_seen = 1'b0;
    stalled   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
    check("post_rst_quiet", 32'(last_ov), 32'd0);
    step(1'b1, 6, 1'b1);
    drain();

    // 8:1 random traffic with random back-pressure
    chk_lat = 1'b0;
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    drain();

    // 32:1 unpipelined, random sel and back-pressure, latency 1
    dut_id  = 1;
    cur_lat = 1;
    chk_lat = 1'b1;
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    drain();

    // 2:1, single level, latency 1
    dut_id  = 2;
    cur_lat = 1;
    step(1'b1, 1, 1'b1);
    step(1'b1, 0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
